// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating direction
// counters, trained by the branch outcome resolved in execute.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      fetch_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    function automatic logic [1:0] sat_cnt2(input logic [1:0] cnt, input logic up);
        if (up)
            return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic             btb_valid [ENTRIES];
    logic [TAG_W-1:0] btb_tag   [ENTRIES];
    logic [29:0]      btb_tgt   [ENTRIES];
    logic [1:0]       btb_cnt   [ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             unused_pc_bits;

    // Instructions are word aligned, so the low two PC bits carry no information.
    assign unused_pc_bits = ^{upd_pc[1:0], upd_target[1:0]};

    // Prediction: combinational lookup on the pre-update contents, no bypass
    assign fetch_idx   = fetch_pc[IDX_W+1:2];
    assign fetch_tag   = fetch_pc[31:IDX_W+2];
    assign fetch_hit   = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
    assign pred_taken  = fetch_hit && btb_cnt[fetch_idx][1];
    assign pred_target = pred_taken ? {btb_tgt[fetch_idx], 2'b00} : fetch_pc + 32'd4;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];
    assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

    // Training: registered update from the execute-stage resolution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_tag[i]   <= '0;
                btb_tgt[i]   <= '0;
                btb_cnt[i]   <= 2'b01;
            end
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (upd_valid) begin
            branch_count <= sat_inc(branch_count);
            if (upd_pred_taken != upd_taken)
                mispredict_count <= sat_inc(mispredict_count);

            if (upd_hit) begin
                btb_cnt[upd_idx] <= sat_cnt2(btb_cnt[upd_idx], upd_taken);
                if (upd_taken)
                    btb_tgt[upd_idx] <= upd_target[31:2];
            end else if (upd_taken) begin
                // Not-taken misses never allocate; a taken miss evicts the occupant.
                btb_valid[upd_idx] <= 1'b1;
                btb_tag[upd_idx]   <= upd_tag;
                btb_tgt[upd_idx]   <= upd_target[31:2];
                btb_cnt[upd_idx]   <= 2'b10;
            end
        end
    end

endmodule
